// File: rtl/spi_flash_cmd.sv
// rtl/spi_flash_cmd.sv - mode-0 SPI flash command engine (opcode/addr/dummy/read); SPI_FLASH_CMD_DEBUG_EN exposes the FSM state
module spi_flash_cmd #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BYTES = 3,
    parameter int MAX_RD     = 256,
    localparam int LEN_W     = $clog2(MAX_RD + 1)
) (
    input  logic                    clk12MHz,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              opcode,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic                    use_addr,
    input  logic [1:0]              dummy_bytes,
    input  logic [LEN_W-1:0]        rd_len,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic                    cs,
    output logic                    sck,
    output logic                    sdo,
    input  logic                    sdi,
    output logic [3:0]              debug_states
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_OPCODE = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_DUMMY  = 3'd4;
    localparam logic [2:0] S_READ   = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;
    localparam logic [2:0] S_GAP    = 3'd7;

    localparam int         CNT_W    = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0]              state;
    logic [7:0]              div_cnt;
    logic [2:0]              bit_cnt;
    logic [CNT_W-1:0]        byte_cnt;
    logic [7:0]              tx_sr;
    logic [6:0]              rx_sr;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic                    use_addr_q;
    logic [1:0]              dummy_q;
    logic [LEN_W-1:0]        rd_len_q;

    logic       half_end;
    logic       last_byte;
    logic [2:0] after_addr;
    logic [2:0] next_phase;
    logic [2:0] load_state;
    logic [7:0] addr_top;

    assign half_end = (div_cnt == DIV_LAST);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_GAP) && half_end;
    assign addr_top = addr_q[8*ADDR_BYTES-1 -: 8];

    // Phase sequencing: empty phases are skipped when the current byte ends.
    always_comb begin
        after_addr = (dummy_q != 2'd0) ? S_DUMMY : ((rd_len_q != '0) ? S_READ : S_HOLD);
        next_phase = S_HOLD;
        last_byte  = 1'b1;
        case (state)
            S_OPCODE: next_phase = use_addr_q ? S_ADDR : after_addr;
            S_ADDR: begin
                next_phase = after_addr;
                last_byte  = (byte_cnt == CNT_W'(ADDR_BYTES - 1));
            end
            S_DUMMY: begin
                next_phase = (rd_len_q != '0) ? S_READ : S_HOLD;
                last_byte  = (byte_cnt == CNT_W'(dummy_q) - CNT_W'(1));
            end
            S_READ: begin
                next_phase = S_HOLD;
                last_byte  = (byte_cnt == CNT_W'(rd_len_q) - CNT_W'(1));
            end
            default: ;
        endcase
        load_state = last_byte ? next_phase : state;
    end

    always_ff @(posedge clk12MHz or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            addr_q     <= '0;
            use_addr_q <= 1'b0;
            dummy_q    <= '0;
            rd_len_q   <= '0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            sdo        <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SETUP;
                        cs         <= 1'b0;
                        sdo        <= opcode[7];
                        tx_sr      <= opcode;
                        addr_q     <= addr;
                        use_addr_q <= use_addr;
                        dummy_q    <= dummy_bytes;
                        rd_len_q   <= rd_len;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        byte_cnt   <= '0;
                    end
                end
                S_SETUP: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        state   <= S_OPCODE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_OPCODE, S_ADDR, S_DUMMY, S_READ: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                            if (state == S_READ) begin
                                rx_sr <= {rx_sr[5:0], sdi};
                                if (bit_cnt == 3'd7) begin
                                    rx_data  <= {rx_sr, sdi};
                                    rx_valid <= 1'b1;
                                end
                            end
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_sr   <= tx_sr << 1;
                                sdo     <= tx_sr[6];
                            end else begin
                                bit_cnt  <= '0;
                                byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
                                if (last_byte)
                                    state <= next_phase;
                                // Next byte's MSB goes out on this falling edge.
                                if (load_state == S_ADDR) begin
                                    tx_sr  <= addr_top;
                                    sdo    <= addr_top[7];
                                    addr_q <= addr_q << 8;
                                end else begin
                                    tx_sr <= '0;
                                    sdo   <= 1'b0;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        state   <= S_GAP;
                        cs      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_FLASH_CMD_DEBUG_EN
    assign debug_states = {1'b0, state};
`else
    assign debug_states = 4'h0;
`endif
endmodule
